// File: rtl/vga_buffer_scanout.sv
// 640x480@60 VGA scan-out of an 80x60 8-bit frame buffer, upscaled by SCALE and gated by frame_ready.
// Build option: define VGA_GRAYSCALE_EN to drive rd_data on red, green and blue (monochrome view).
module vga_buffer_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SRC_W      = 80,
  parameter int SRC_H      = 60,
  parameter int SCALE      = 8,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk_vga,
  input  logic                  rst,
  input  logic                  frame_ready,
  output logic                  rd_en_vga,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank_n,
  output logic [7:0]            red,
  output logic [7:0]            green,
  output logic [7:0]            blue,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int CW      = (SRC_W > 1) ? $clog2(SRC_W) : 1;

  if (H_ACTIVE != SRC_W * SCALE || V_ACTIVE != SRC_H * SCALE ||
      SRC_W * SRC_H > 2 ** ADDR_WIDTH) begin : g_bad_cfg
    $error("vga_buffer_scanout: inconsistent geometry parameters");
  end

  typedef enum logic [1:0] {WAIT_READY, ARMED, SCAN} state_t;

  state_t                state, state_nxt;
  logic [HW-1:0]         hcnt, h_nxt;
  logic [VW-1:0]         vcnt, v_nxt;
  logic                  h_last, v_last, frame_end, visible;
  logic                  rdy_meta, rdy_s;
  logic [SW-1:0]         px_sub, ln_sub;
  logic [CW-1:0]         col;
  logic [ADDR_WIDTH-1:0] line_base, addr_hold;
  logic                  hs1, vs1, vis1, en1;
  logic [7:0]            pix_r, pix_g, pix_b;

  assign h_last    = (hcnt == HW'(H_TOTAL - 1));
  assign v_last    = (vcnt == VW'(V_TOTAL - 1));
  assign frame_end = h_last && v_last;
  assign h_nxt     = h_last ? '0 : hcnt + 1'b1;
  assign v_nxt     = h_last ? (v_last ? '0 : vcnt + 1'b1) : vcnt;
  assign visible   = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      hcnt     <= '0;
      vcnt     <= '0;
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
      state    <= WAIT_READY;
    end else begin
      hcnt     <= h_nxt;
      vcnt     <= v_nxt;
      rdy_meta <= frame_ready;
      rdy_s    <= rdy_meta;
      state    <= state_nxt;
    end
  end

  // Transitions fire on the edge that enters hcnt=0,vcnt=0, so SCAN owns the whole frame.
  // NOTE: defaulting state_nxt first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_READY: if (rdy_s) state_nxt = ARMED;
      ARMED:      if (frame_end) state_nxt = SCAN;
      SCAN:       if (frame_end && !rdy_s) state_nxt = WAIT_READY;
      default:    state_nxt = WAIT_READY;
    endcase
  end

  // Column and line-base trackers step towards the position the counters move to next.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      px_sub    <= '0;
      col       <= '0;
      ln_sub    <= '0;
      line_base <= '0;
    end else begin
      if (h_nxt == '0) begin
        px_sub <= '0;
        col    <= '0;
      end else if (h_nxt < HW'(H_ACTIVE)) begin
        if (px_sub == SW'(SCALE - 1)) begin
          px_sub <= '0;
          col    <= col + 1'b1;
        end else begin
          px_sub <= px_sub + 1'b1;
        end
      end
      if (frame_end) begin
        ln_sub    <= '0;
        line_base <= '0;
      end else if (h_last && (v_nxt < VW'(V_ACTIVE))) begin
        if (ln_sub == SW'(SCALE - 1)) begin
          ln_sub    <= '0;
          line_base <= line_base + ADDR_WIDTH'(SRC_W);
        end else begin
          ln_sub <= ln_sub + 1'b1;
        end
      end
    end
  end

  assign rd_en_vga = (state == SCAN) && visible;
  assign rd_addr   = rd_en_vga ? line_base + ADDR_WIDTH'(col) : addr_hold;

  // Counters already rest at 0,0 during reset; the pulse is held off until release.
  assign frame_start = !rst && (hcnt == '0) && (vcnt == '0);

`ifdef VGA_GRAYSCALE_EN
  assign pix_r = rd_data;
  assign pix_g = rd_data;
  assign pix_b = rd_data;
`else
  assign pix_r = {rd_data[7:3], rd_data[7:5]};
  assign pix_g = {rd_data[2:0], rd_data[2:0], rd_data[2:1]};
  assign pix_b = 8'h00;
`endif

  // Sync/blank ride two stages so they line up with RGB built from the RAM's registered output.
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      addr_hold <= '0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      vis1      <= 1'b0;
      en1       <= 1'b0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      blank_n   <= 1'b0;
      red       <= 8'h00;
      green     <= 8'h00;
      blue      <= 8'h00;
    end else begin
      addr_hold <= rd_addr;
      hs1       <= !((hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
      vs1       <= !((vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
      vis1      <= visible;
      en1       <= rd_en_vga;
      hsync     <= hs1;
      vsync     <= vs1;
      blank_n   <= vis1;
      red       <= en1 ? pix_r : 8'h00;
      green     <= en1 ? pix_g : 8'h00;
      blue      <= en1 ? pix_b : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_buffer_scanout.sv
// Self-checking bench for vga_buffer_scanout on a reduced raster (40x24 visible, 10x6 source, x4).
// RAM model returns ~addr[7:0] one clock after a strobed read.
module tb_vga_buffer_scanout;

  localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int SRC_W = 10, SRC_H = 6, SCALE = 4, AW = 13;
  localparam int HT = 56, VT = 31, FRAME = HT * VT, LAST_ADDR = 59;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_ready = 1'b0;
  logic          rd_en_vga;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data = 8'h00;
  logic          hsync, vsync, blank_n, frame_start;
  logic [7:0]    red, green, blue;

  vga_buffer_scanout #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE(SCALE), .ADDR_WIDTH(AW)
  ) dut (
    .clk_vga(clk), .rst(rst), .frame_ready(frame_ready),
    .rd_en_vga(rd_en_vga), .rd_addr(rd_addr), .rd_data(rd_data),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .red(red), .green(green), .blue(blue), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en_vga) rd_data <= ~rd_addr[7:0];

  // Reference raster position, restarted by reset exactly like the pixel counters.
  int tb_h = 0, tb_v = 0, cyc = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_h <= 0;
      tb_v <= 0;
    end else if (tb_h == HT - 1) begin
      tb_h <= 0;
      tb_v <= (tb_v == VT - 1) ? 0 : tb_v + 1;
    end else begin
      tb_h <= tb_h + 1;
    end
  end
  always @(posedge clk) cyc <= cyc + 1;

  int  fs_err = 0, addr_over = 0, blank_err = 0, idle_viol = 0;
  int  hs_last = 0, hs_period = 0, vs_last = 0, vs_period = 0;
  bit  watch_idle = 0;
  logic hs_prev = 1'b1, vs_prev = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_start !== (tb_h == 0 && tb_v == 0)) fs_err++;
      if (rd_en_vga && rd_addr > LAST_ADDR) addr_over++;
      if (!blank_n && {red, green, blue} != 24'h0) blank_err++;
      if (watch_idle && (rd_en_vga || {red, green, blue} != 24'h0)) idle_viol++;
      if (hs_prev && !hsync) begin
        hs_period = cyc - hs_last;
        hs_last   = cyc;
      end
      if (vs_prev && !vsync) begin
        vs_period = cyc - vs_last;
        vs_last   = cyc;
      end
      hs_prev = hsync;
      vs_prev = vsync;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic goto(input int h, input int v);
    bit found = 0;
    for (int n = 0; n < FRAME + 2 && !found; n++) begin
      @(negedge clk);
      if (tb_h == h && tb_v == v) found = 1;
    end
    check($sformatf("reach_%0d_%0d", h, v), 32'(found), 32'd1);
  endtask

  function automatic logic [7:0] exp_r(input logic [7:0] d, input logic [7:0] r);
`ifdef VGA_GRAYSCALE_EN
    return d;
`else
    return r;
`endif
  endfunction

  function automatic logic [7:0] exp_g(input logic [7:0] d, input logic [7:0] g);
`ifdef VGA_GRAYSCALE_EN
    return d;
`else
    return g;
`endif
  endfunction

  function automatic logic [7:0] exp_b(input logic [7:0] d);
`ifdef VGA_GRAYSCALE_EN
    return d;
`else
    return 8'h00;
`endif
  endfunction

  typedef struct {
    int         x;
    int         y;
    int         addr;
    logic [7:0] d;
    logic [7:0] r;
    logic [7:0] g;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #(FRAME * 12 * 10);
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    vecs[0] = '{x: 5,  y: 1,  addr: 1,  d: 8'hFE, r: 8'hFF, g: 8'hDB};
    vecs[1] = '{x: 39, y: 3,  addr: 9,  d: 8'hF6, r: 8'hF7, g: 8'hDB};
    vecs[2] = '{x: 17, y: 9,  addr: 24, d: 8'hE7, r: 8'hE7, g: 8'hFF};
    vecs[3] = '{x: 22, y: 13, addr: 35, d: 8'hDC, r: 8'hDE, g: 8'h92};
    vecs[4] = '{x: 30, y: 17, addr: 47, d: 8'hD0, r: 8'hD6, g: 8'h00};
    vecs[5] = '{x: 39, y: 23, addr: 59, d: 8'hC4, r: 8'hC6, g: 8'h92};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_blank_n", blank_n, 0);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_rd_en", rd_en_vga, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_frame_start", frame_start, 0);
    rst = 1'b0;
    #1;
    check("release_frame_start", frame_start, 1);
    watch_idle = 1;
    base = idle_viol;

    // Two idle frames: sync placement (2-clk pin latency) and periods
    goto(45, 0); check("hsync_before_pulse", hsync, 1);
    goto(46, 0); check("hsync_pulse_start", hsync, 0);
    goto(53, 0); check("hsync_pulse_end", hsync, 0);
    goto(54, 0); check("hsync_after_pulse", hsync, 1);
    goto(1, 26); check("vsync_before_pulse", vsync, 1);
    goto(2, 26); check("vsync_pulse_start", vsync, 0);
    goto(1, 28); check("vsync_pulse_end", vsync, 0);
    goto(2, 28); check("vsync_after_pulse", vsync, 1);
    goto(HT - 1, VT - 1);
    goto(HT - 1, VT - 1);
    check("hsync_period", hs_period, HT);
    check("vsync_period", vs_period, FRAME);

    // frame_ready raised mid-frame: no reads until the next frame begins
    goto(0, 10);
    frame_ready = 1'b1;
    goto(HT - 1, VT - 1);
    watch_idle = 0;
    check("idle_until_armed_frame", idle_viol - base, 0);
    goto(0, 0);
    check("scan_first_rd_en", rd_en_vga, 1);
    check("scan_first_addr", rd_addr, 0);
    goto(SCALE - 1, 0); check("addr_held_scale", rd_addr, 0);
    goto(SCALE, 0);     check("addr_next_col", rd_addr, 1);

    for (int i = 0; i < 6; i++) begin
      goto(vecs[i].x, vecs[i].y);
      check($sformatf("v%0d_rd_en", i), rd_en_vga, 1);
      check($sformatf("v%0d_addr", i), rd_addr, vecs[i].addr);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_blank_n", i), blank_n, 1);
      check($sformatf("v%0d_red", i), red, exp_r(vecs[i].d, vecs[i].r));
      check($sformatf("v%0d_green", i), green, exp_g(vecs[i].d, vecs[i].g));
      check($sformatf("v%0d_blue", i), blue, exp_b(vecs[i].d));
    end

    // Past the last visible pixel: strobe off, address holds at the last one
    goto(42, 23);
    check("after_last_rd_en", rd_en_vga, 0);
    check("after_last_addr", rd_addr, LAST_ADDR);
    check("after_last_blank_n", blank_n, 0);
    check("after_last_red", red, 0);

    // frame_ready dropped mid-scan: frame completes, the next one is black
    goto(0, 5);
    frame_ready = 1'b0;
    goto(39, 23);
    check("drop_last_rd_en", rd_en_vga, 1);
    check("drop_last_addr", rd_addr, LAST_ADDR);
    goto(HT - 1, VT - 1);
    base = idle_viol;
    watch_idle = 1;
    goto(0, 0);
    check("drop_next_rd_en", rd_en_vga, 0);
    goto(0, 1);
    frame_ready = 1'b1;
    goto(HT - 1, VT - 1);
    watch_idle = 0;
    check("drop_next_frame_black", idle_viol - base, 0);

    // Asynchronous reset mid-scan
    goto(30, 12);
    check("pre_rst_rd_en", rd_en_vga, 1);
    check("pre_rst_red", red, exp_r(8'hDA, 8'hDE));
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", rd_en_vga, 0);
    check("mid_rst_addr", rd_addr, 0);
    check("mid_rst_blank_n", blank_n, 0);
    check("mid_rst_rgb", {red, green, blue}, 0);
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_frame_start", frame_start, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rerelease_frame_start", frame_start, 1);
    base = idle_viol;
    watch_idle = 1;
    goto(5, 0);
    check("post_rst_no_partial", rd_en_vga, 0);
    goto(HT - 1, VT - 1);
    watch_idle = 0;
    check("post_rst_frame_black", idle_viol - base, 0);
    goto(0, 0);
    check("rescan_rd_en", rd_en_vga, 1);
    check("rescan_addr", rd_addr, 0);
    goto(2, 0);
    check("rescan_red", red, exp_r(8'hFF, 8'hFF));

    check("frame_start_alignment_errors", fs_err, 0);
    check("addr_overrun_count", addr_over, 0);
    check("rgb_during_blank_count", blank_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
